// File: rtl/move_writeback.sv
// 3x3 move write-back: places three canonical merged lines back into board orientation and commits.
// Optional MOVE_WB_CHANGE_DETECT_EN keeps a pre-move snapshot so `changed` reflects a real difference.
module move_writeback #(
  parameter int TILE_W = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [1:0]          i_dir,
  input  logic [9*TILE_W-1:0] i_cur_board,
  input  logic                i_line_valid,
  output logic                o_line_ready,
  input  logic [3*TILE_W-1:0] i_line_data,
  output logic                o_busy,
  output logic                o_done,
  output logic [9*TILE_W-1:0] o_board_out,
  output logic                o_changed
);
  localparam int BW = 9 * TILE_W;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cnt, r_dir;
  logic [BW-1:0]    r_asm, w_asm_nxt;
  logic             w_accept;
  logic [2:0][3:0]  w_tile;     // board tile index (row*3+col) for canonical position k

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_accept && r_cnt == 2'd2) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_line_ready = (r_state == S_COLLECT);
    w_accept     = o_line_ready & i_line_valid;
    w_tile       = '0;
    for (int k = 0; k < 3; k++) begin
      case (r_dir)
        2'b00:   w_tile[k] = {2'b0, r_cnt} * 4'd3 + 4'(k);
        2'b01:   w_tile[k] = {2'b0, r_cnt} * 4'd3 + 4'(2 - k);
        2'b10:   w_tile[k] = 4'(k) * 4'd3 + {2'b0, r_cnt};
        default: w_tile[k] = 4'(2 - k) * 4'd3 + {2'b0, r_cnt};
      endcase
    end
    w_asm_nxt = r_asm;
    for (int t = 0; t < 9; t++)
      for (int k = 0; k < 3; k++)
        if (w_tile[k] == 4'(t))
          w_asm_nxt[t*TILE_W +: TILE_W] = i_line_data[k*TILE_W +: TILE_W];
  end

`ifdef MOVE_WB_CHANGE_DETECT_EN
  logic [BW-1:0] r_snap;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                          r_snap <= '0;
    else if (r_state == S_IDLE && i_start) r_snap <= i_cur_board;
  end
  wire w_changed = (w_asm_nxt != r_snap);
`else
  wire w_changed = 1'b1;
  logic w_unused_cur;
  assign w_unused_cur = ^i_cur_board;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_dir       <= '0;
      r_asm       <= '0;
      o_board_out <= '0;
      o_done      <= 1'b0;
      o_changed   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_done <= (w_state_nxt == S_DONE);
      o_busy <= (w_state_nxt != S_IDLE);
      if (r_state == S_IDLE && i_start) begin
        r_dir <= i_dir;
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_asm <= w_asm_nxt;
        r_cnt <= r_cnt + 2'd1;
      end
      // Commit uses the bypassed assembly so the last line lands on the same edge as done.
      if (w_accept && r_cnt == 2'd2) begin
        o_board_out <= w_asm_nxt;
        o_changed   <= w_changed;
      end
    end
  end
endmodule

// File: tb/tb_move_writeback.sv
// Directed bench for move_writeback: orientation placement, latency, stalls, ignores and reset abort.
module tb_move_writeback;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, line_valid = 1'b0;
  logic [1:0]  dir = 2'b00;
  logic [26:0] cur_board = '0;
  logic [8:0]  line_data = '0;
  logic        o_line_ready, o_busy, o_done, o_changed;
  logic [26:0] o_board_out;

  int n_tests = 0, n_fail = 0;

  move_writeback #(.TILE_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dir(dir), .i_cur_board(cur_board),
    .i_line_valid(line_valid), .o_line_ready(o_line_ready), .i_line_data(line_data),
    .o_busy(o_busy), .o_done(o_done), .o_board_out(o_board_out), .o_changed(o_changed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

`ifdef MOVE_WB_CHANGE_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [26:0] mk(input logic [8:0] r2, input logic [8:0] r1, input logic [8:0] r0);
    return {r2, r1, r0};
  endfunction

  // Results captured by the commit driver (no checking inside)
  logic [26:0] r_board;
  logic        r_chg, r_seen, r_busy1, r_busy_done;
  int          r_lat;

  task automatic run_commit(input logic [1:0] d, input logic [26:0] cb, input logic [8:0] l0,
                            input logic [8:0] l1, input logic [8:0] l2, input int stall, input bit poke);
    logic [8:0] lines [3];
    lines = '{l0, l1, l2};
    dir = d; cur_board = cb; start = 1'b1;
    tick; r_lat = 1; start = 1'b0;
    r_busy1 = o_busy & o_line_ready;
    for (int i = 0; i < 3; i++) begin
      if (i == 1)
        for (int s = 0; s < stall; s++) begin
          line_valid = 1'b0; start = poke; dir = poke ? ~d : d;
          tick; r_lat++;
          start = 1'b0; dir = d;
        end
      line_valid = 1'b1; line_data = lines[i];
      tick; r_lat++;
    end
    line_valid = 1'b0; line_data = '0;
    for (int w = 0; w < 20 && !o_done; w++) begin tick; r_lat++; end
    r_seen = o_done; r_board = o_board_out; r_chg = o_changed; r_busy_done = o_busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick; tick;
    n_tests++;
    if ({o_done, o_busy, o_line_ready, o_changed, o_board_out} !== 31'd0) begin
      n_fail++; $display("FAIL reset_state: got done=%b busy=%b rdy=%b chg=%b board=%o, want all 0",
                         o_done, o_busy, o_line_ready, o_changed, o_board_out);
    end
    rst_n = 1'b1; line_valid = 1'b1; line_data = 9'o777;
    for (int c = 0; c < 5; c++) begin
      tick;
      n_tests++;
      if ({o_done, o_busy, o_line_ready, o_board_out} !== 30'd0) begin
        n_fail++; $display("FAIL idle_cycle%0d: got done=%b busy=%b rdy=%b board=%o, want all 0",
                           c, o_done, o_busy, o_line_ready, o_board_out);
      end
    end
    line_valid = 1'b0; line_data = '0;
  endtask

  task automatic test_right;
    run_commit(2'b01, '0, 9'o001, 9'o012, 9'o000, 0, 1'b0);
    n_tests++;
    if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL right_busy_t1: got %b want 1", r_busy1); end
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 4) begin
      n_fail++; $display("FAIL right_latency: got done=%b lat=%0d want done=1 lat=4", r_seen, r_lat);
    end
    n_tests++;
    if (r_board !== mk(9'o000, 9'o210, 9'o100)) begin
      n_fail++; $display("FAIL right_board: got %o want %o", r_board, mk(9'o000, 9'o210, 9'o100));
    end
    n_tests++;
    if (r_chg !== 1'b1 || r_busy_done !== 1'b1) begin
      n_fail++; $display("FAIL right_flags: got chg=%b busy=%b want 1 1", r_chg, r_busy_done);
    end
    tick;
    n_tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_board_out !== mk(9'o000, 9'o210, 9'o100)) begin
      n_fail++; $display("FAIL right_after_done: got done=%b busy=%b board=%o want 0 0 %o",
                         o_done, o_busy, o_board_out, mk(9'o000, 9'o210, 9'o100));
    end
  endtask

  task automatic test_up_down;
    run_commit(2'b10, '0, 9'o001, 9'o002, 9'o003, 0, 1'b0);
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 4 || r_board !== mk(9'o000, 9'o000, 9'o321)) begin
      n_fail++; $display("FAIL up_board: got done=%b lat=%0d board=%o want 1 4 %o",
                         r_seen, r_lat, r_board, mk(9'o000, 9'o000, 9'o321));
    end
    tick;
    run_commit(2'b11, '0, 9'o001, 9'o002, 9'o003, 0, 1'b0);
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 4 || r_board !== mk(9'o321, 9'o000, 9'o000)) begin
      n_fail++; $display("FAIL down_board: got done=%b lat=%0d board=%o want 1 4 %o",
                         r_seen, r_lat, r_board, mk(9'o321, 9'o000, 9'o000));
    end
    tick;
  endtask

  task automatic test_changed;
    run_commit(2'b00, mk(9'o000, 9'o000, 9'o021), 9'o021, 9'o000, 9'o000, 0, 1'b0);
    n_tests++;
    if (r_board !== mk(9'o000, 9'o000, 9'o021) || r_chg !== !CD) begin
      n_fail++; $display("FAIL unchanged_move: got board=%o chg=%b want %o %b",
                         r_board, r_chg, mk(9'o000, 9'o000, 9'o021), !CD);
    end
    tick;
    run_commit(2'b00, mk(9'o000, 9'o000, 9'o021), 9'o012, 9'o000, 9'o000, 0, 1'b0);
    n_tests++;
    if (r_board !== mk(9'o000, 9'o000, 9'o012) || r_chg !== 1'b1) begin
      n_fail++; $display("FAIL changed_move: got board=%o chg=%b want %o 1",
                         r_board, r_chg, mk(9'o000, 9'o000, 9'o012));
    end
    tick;
  endtask

  task automatic test_stall_ignore;
    run_commit(2'b01, '0, 9'o001, 9'o012, 9'o000, 3, 1'b0);
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 7 || r_board !== mk(9'o000, 9'o210, 9'o100)) begin
      n_fail++; $display("FAIL stall3: got done=%b lat=%0d board=%o want 1 7 %o",
                         r_seen, r_lat, r_board, mk(9'o000, 9'o210, 9'o100));
    end
    tick;
    run_commit(2'b00, '0, 9'o001, 9'o012, 9'o000, 2, 1'b1);
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 6 || r_board !== mk(9'o000, 9'o012, 9'o001)) begin
      n_fail++; $display("FAIL start_in_collect: got done=%b lat=%0d board=%o want 1 6 %o",
                         r_seen, r_lat, r_board, mk(9'o000, 9'o012, 9'o001));
    end
    tick;
  endtask

  task automatic test_reset_mid;
    dir = 2'b00; cur_board = '0; start = 1'b1; tick; start = 1'b0;
    line_valid = 1'b1; line_data = 9'o123; tick;
    line_data = 9'o456; tick;
    line_valid = 1'b0; rst_n = 1'b0; tick; rst_n = 1'b1;
    n_tests++;
    if (o_busy !== 1'b0 || o_board_out !== 27'd0 || o_done !== 1'b0 || o_line_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got busy=%b board=%o done=%b rdy=%b want 0 0 0 0",
                         o_busy, o_board_out, o_done, o_line_ready);
    end
    line_valid = 1'b1; line_data = 9'o777;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle%0d: got done=%b busy=%b want 0 0", c, o_done, o_busy);
      end
    end
    line_valid = 1'b0;
    run_commit(2'b11, '0, 9'o001, 9'o002, 9'o003, 0, 1'b0);
    n_tests++;
    if (r_seen !== 1'b1 || r_lat != 4 || r_board !== mk(9'o321, 9'o000, 9'o000) || r_chg !== 1'b1) begin
      n_fail++; $display("FAIL recommit: got done=%b lat=%0d board=%o chg=%b want 1 4 %o 1",
                         r_seen, r_lat, r_board, r_chg, mk(9'o321, 9'o000, 9'o000));
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_right;
    test_up_down;
    test_changed;
    test_stall_ignore;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
